// File: rtl/tpm_frame_scheduler_pkg.sv
// Shared types and defaults for the tactile pressure matrix frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tpm_frame_scheduler_pkg;

    localparam int DEF_ROWS       = 32;
    localparam int DEF_COLS       = 32;
    localparam int DEF_ADC_BITS   = 12;
    localparam int DEF_SETTLE     = 4;
    localparam int DEF_ADC_TMO    = 255;
    localparam int FRAME_CNT_BITS = 16;

    // Scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CONV   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4,
        ST_FEND   = 3'd5
    } state_t;

    // The shared timer is loaded with SETTLE-1 or ADC_TMO-1, so it must hold
    // values up to max(SETTLE, ADC_TMO)-1.
    function automatic int timer_bits(input int settle, input int tmo);
        int m;
        m = (settle > tmo) ? settle : tmo;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tpm_frame_scheduler_if.sv
// Sample stream from the frame scheduler to the downstream consumer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready; producer holds payload until out_valid & out_ready.
interface tpm_frame_scheduler_if
    import tpm_frame_scheduler_pkg::*;
#(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 5,
    parameter int ADC_BITS = DEF_ADC_BITS
);
    logic                out_valid;
    logic                out_ready;
    logic [ADC_BITS-1:0] out_data;
    logic [ROW_BITS-1:0] out_row;
    logic [COL_BITS-1:0] out_col;
    logic                out_last;
    logic                out_err;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last, out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last, out_err,
        output out_ready
    );
endinterface

// File: rtl/tpm_frame_scheduler_settle_timer.sv
// Loadable down-counter with zero flag; times row settling and ADC timeout.
// Latency: load/decrement take effect on the next falling clock edge.
// Backpressure: none; holds at zero until reloaded.
module tpm_settle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(negedge clock_in) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/tpm_frame_scheduler.sv
// Scans the pressure matrix row by row, one ADC conversion per column, and streams samples.
// Latency: sample valid one cycle after adc_done (or ADC_TMO wait cycles after the request).
// Backpressure: EMIT holds the sample until accepted; no new conversion starts meanwhile.
module tpm_frame_scheduler
    import tpm_frame_scheduler_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 5,
    parameter int ADC_BITS = DEF_ADC_BITS,
    parameter int SETTLE   = DEF_SETTLE,
    parameter int ADC_TMO  = DEF_ADC_TMO
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic                      scan_en,
    input  logic                      single_shot,
    input  logic                      adc_done,
    input  logic [ADC_BITS-1:0]       adc_data,
    output logic [ROW_BITS-1:0]       row_sel,
    output logic [COL_BITS-1:0]       col_sel,
    output logic                      row_drive,
    output logic                      adc_start,
    output logic                      busy,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt,
    tpm_frame_scheduler_if.master     smp
);
    localparam int                  TMR_W     = timer_bits(SETTLE, ADC_TMO);
    localparam logic [TMR_W-1:0]    SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]    TMO_LD    = TMR_W'(ADC_TMO - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(COLS - 1);

    state_t           state;
    logic             start_req;
    logic             row_end;
    logic             frame_end;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    // single_shot together with scan_en behaves exactly like scan_en alone
    assign start_req = scan_en | single_shot;
    assign row_end   = (col_sel == COL_LAST);
    assign frame_end = row_end && (row_sel == ROW_LAST);

    // Timer reload points: every entry into SETTLE, and the CONV->WAIT step
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;
        case (state)
            ST_IDLE: tmr_load = start_req;
            ST_CONV: begin
                tmr_load = 1'b1;
                tmr_val  = TMO_LD;
            end
            ST_EMIT: tmr_load = smp.out_ready && row_end && !frame_end;
            ST_FEND: tmr_load = scan_en;
            default: tmr_load = 1'b0;
        endcase
    end

    assign tmr_dec = (state == ST_SETTLE) || (state == ST_WAIT);

    tpm_settle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clock_in (clock_in),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Scan sequencer with registered control and sample outputs
    always_ff @(negedge clock_in) begin
        if (reset) begin
            state         <= ST_IDLE;
            row_sel       <= '0;
            col_sel       <= '0;
            row_drive     <= 1'b0;
            adc_start     <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= '0;
            smp.out_valid <= 1'b0;
            smp.out_data  <= '0;
            smp.out_row   <= '0;
            smp.out_col   <= '0;
            smp.out_last  <= 1'b0;
            smp.out_err   <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_SETTLE;
                        row_sel   <= '0;
                        col_sel   <= '0;
                        row_drive <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state     <= ST_CONV;
                        adc_start <= 1'b1;
                    end
                end
                ST_CONV: begin
                    // a done pulse coincident with the request belongs to nothing
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (adc_done || tmr_zero) begin
                        state         <= ST_EMIT;
                        smp.out_valid <= 1'b1;
                        smp.out_data  <= adc_done ? adc_data : '0;
                        smp.out_err   <= !adc_done;
                        smp.out_row   <= row_sel;
                        smp.out_col   <= col_sel;
                        smp.out_last  <= frame_end;
                    end
                end
                ST_EMIT: begin
                    if (smp.out_ready) begin
                        smp.out_valid <= 1'b0;
                        if (!row_end) begin
                            col_sel   <= col_sel + 1'b1;
                            state     <= ST_CONV;
                            adc_start <= 1'b1;
                        end else if (!frame_end) begin
                            row_sel <= row_sel + 1'b1;
                            col_sel <= '0;
                            state   <= ST_SETTLE;
                        end else begin
                            state     <= ST_FEND;
                            row_drive <= 1'b0;
                        end
                    end
                end
                ST_FEND: begin
                    frame_cnt <= frame_cnt + 1'b1;
                    row_sel   <= '0;
                    col_sel   <= '0;
                    if (scan_en) begin
                        state     <= ST_SETTLE;
                        row_drive <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    row_drive <= 1'b0;
                end
            endcase
        end
    end
endmodule
